// File: rtl/ascii_scroll_display_if.sv
`default_nettype none
// ============================================================================
// Module      : ascii_scroll_display_if
// Description : Byte write channel (valid/ready) into the scrolling display.
// Revision    : 1.0 - initial release
// ============================================================================
interface ascii_scroll_display_if;
    logic       wr_valid;
    logic [7:0] wr_data;
    logic       wr_ready;

    modport master (output wr_valid, output wr_data, input  wr_ready);
    modport slave  (input  wr_valid, input  wr_data, output wr_ready);
endinterface
`default_nettype wire

// File: rtl/ascii_scroll_display.sv
`default_nettype none
// ============================================================================
// Module      : ascii_scroll_display
// Description : Buffered ASCII message shown on a seven-segment bank,
//               statically or as a right-to-left marquee.
// Revision    : 1.0 - initial release
// ============================================================================
module ascii_scroll_display #(
    parameter int NUM_DIGITS = 6,
    parameter int DEPTH      = 32,
    parameter int TICK_DIV   = 25000000
) (
    input  wire logic                          clk,
    input  wire logic                          rst_n,
    ascii_scroll_display_if.slave              bus,
    input  wire logic                          clr,
    input  wire logic                          scroll_en,
    output logic [$clog2(DEPTH+1)-1:0]         len,
    output logic                               step,
    output logic [7*NUM_DIGITS-1:0]            hex_seg
);

    localparam int c_LW = $clog2(DEPTH + 1);
    localparam int c_AW = $clog2(DEPTH);
    localparam int c_PW = $clog2(DEPTH + 2*NUM_DIGITS + 1);
    localparam int c_TW = $clog2(TICK_DIV);
    localparam logic [c_TW-1:0] c_TICK_LAST = c_TW'(TICK_DIV - 1);

    logic [7:0]            r_buf [DEPTH];
    logic [c_LW-1:0]       r_len;
    logic [c_PW-1:0]       r_off;
    logic [c_TW-1:0]       r_tick;
    logic                  r_step;
    logic [7*NUM_DIGITS-1:0] r_hex;

    logic                  w_ready;
    logic                  w_accept;
    logic                  w_run;
    logic                  w_wrap;
    logic [c_PW-1:0]       w_seqlen;
    logic [c_PW-1:0]       w_off_inc;
    logic [7*NUM_DIGITS-1:0] w_hex_next;

    function automatic logic [6:0] f_glyph(input logic [7:0] b);
        logic [7:0] w_up;
        logic [6:0] w_g;
        w_up = (b >= 8'h61 && b <= 8'h7A) ? (b - 8'h20) : b;
        case (w_up)
            8'h00, 8'h30: w_g = 7'h40;
            8'h01, 8'h31: w_g = 7'h79;
            8'h02, 8'h32: w_g = 7'h24;
            8'h03, 8'h33: w_g = 7'h30;
            8'h04, 8'h34: w_g = 7'h19;
            8'h05, 8'h35: w_g = 7'h12;
            8'h06, 8'h36: w_g = 7'h02;
            8'h07, 8'h37: w_g = 7'h78;
            8'h08, 8'h38: w_g = 7'h00;
            8'h09, 8'h39: w_g = 7'h10;
            8'h0A, 8'h41: w_g = 7'h08;
            8'h0B, 8'h42: w_g = 7'h03;
            8'h0C, 8'h43: w_g = 7'h46;
            8'h0D, 8'h44: w_g = 7'h21;
            8'h0E, 8'h45: w_g = 7'h06;
            8'h0F, 8'h46: w_g = 7'h0E;
            8'h47: w_g = 7'h10;
            8'h48: w_g = 7'h09;
            8'h49: w_g = 7'h4F;
            8'h4A: w_g = 7'h61;
            8'h4B: w_g = 7'h09;
            8'h4C: w_g = 7'h47;
            8'h4D: w_g = 7'h6A;
            8'h4E: w_g = 7'h2A;
            8'h4F: w_g = 7'h40;
            8'h50: w_g = 7'h0C;
            8'h51: w_g = 7'h18;
            8'h52: w_g = 7'h2F;
            8'h53: w_g = 7'h12;
            8'h54: w_g = 7'h07;
            8'h55: w_g = 7'h41;
            8'h56: w_g = 7'h63;
            8'h57: w_g = 7'h55;
            8'h58: w_g = 7'h09;
            8'h59: w_g = 7'h11;
            8'h5A: w_g = 7'h24;
            8'h20: w_g = 7'h7F;
            8'h27: w_g = 7'h7D;
            default: w_g = 7'h3F;
        endcase
        return w_g;
    endfunction

    assign w_ready   = (r_len != c_LW'(DEPTH));
    assign w_accept  = bus.wr_valid & w_ready & ~clr;
    assign w_run     = scroll_en & (r_len != '0);
    assign w_wrap    = (r_tick == c_TICK_LAST);
    assign w_seqlen  = c_PW'(r_len) + c_PW'(NUM_DIGITS);
    assign w_off_inc = r_off + c_PW'(1);

    // Step wraps against the pre-write sequence length; a same-cycle write only grows L.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_len  <= '0;
            r_off  <= '0;
            r_tick <= '0;
            r_step <= 1'b0;
        end else if (clr) begin
            r_len  <= '0;
            r_off  <= '0;
            r_tick <= '0;
            r_step <= 1'b0;
        end else begin
            if (w_accept) begin
                r_len <= r_len + c_LW'(1);
            end
            if (!w_run) begin
                r_tick <= '0;
                r_off  <= '0;
                r_step <= 1'b0;
            end else if (w_wrap) begin
                r_tick <= '0;
                r_step <= 1'b1;
                r_off  <= (w_off_inc >= w_seqlen) ? '0 : w_off_inc;
            end else begin
                r_tick <= r_tick + c_TW'(1);
                r_step <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_buf[r_len[c_AW-1:0]] <= bus.wr_data;
        end
    end

    // Offset < L and k < NUM_DIGITS <= L, so a single subtraction wraps the position.
    for (genvar k = 0; k < NUM_DIGITS; k++) begin : g_digit
        logic [c_PW-1:0] w_raw;
        logic [c_PW-1:0] w_pos;
        assign w_raw = r_off + c_PW'(k);
        assign w_pos = (w_raw >= w_seqlen) ? (w_raw - w_seqlen) : w_raw;
        assign w_hex_next[7*(NUM_DIGITS-1-k) +: 7] =
            (w_pos < c_PW'(r_len)) ? f_glyph(r_buf[w_pos[c_AW-1:0]]) : 7'h7F;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_hex <= '1;
        end else begin
            r_hex <= w_hex_next;
        end
    end

    assign bus.wr_ready = w_ready;
    assign len          = r_len;
    assign step         = r_step;
    assign hex_seg      = r_hex;

endmodule
`default_nettype wire
